// File: rtl/pingpong_skew_feeder_if.sv
// Write-stream, control and skewed lane-output bundle for pingpong_skew_feeder.
// The master side drives the write beats and stream control, and the slave side is the feeder.
interface pingpong_skew_feeder_if #(
    parameter int LANES      = 8,
    parameter int DATA_WIDTH = 32
);
    logic                          wr_valid_i;
    logic [DATA_WIDTH-1:0]         wr_data_i;
    logic                          wr_ready_o;
    logic                          start_i;
    logic                          advance_i;
    logic [LANES*DATA_WIDTH-1:0]   data_o;
    logic [LANES-1:0]              valid_o;
    logic [LANES-1:0]              last_o;
    logic [1:0]                    bank_full_o;
    logic                          busy_o;
    logic                          done_o;

    modport master (
        output wr_valid_i, wr_data_i, start_i, advance_i,
        input  wr_ready_o, data_o, valid_o, last_o, bank_full_o, busy_o, done_o
    );

    modport slave (
        input  wr_valid_i, wr_data_i, start_i, advance_i,
        output wr_ready_o, data_o, valid_o, last_o, bank_full_o, busy_o, done_o
    );
endinterface

// File: rtl/pingpong_skew_feeder.sv
// Double-buffered mesh-edge feeder: one bank loads lane-major while the other bank streams.
// The stream is diagonally skewed so that lane i lags lane 0 by i cycles.
module pingpong_skew_feeder #(
    parameter int LANES      = 8,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int AUTO_START = 0
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    flush_i,
    pingpong_skew_feeder_if.slave   bus
);
    localparam int STEPS = DEPTH + LANES - 1;
    localparam int TW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int EW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW    = $clog2(2 * DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                      state_reg, state_next;
    logic [TW-1:0]               step_reg, step_next;
    logic                        rb_reg, rb_next;
    logic                        wb_reg;
    logic [LW-1:0]               wr_lane_reg;
    logic [EW-1:0]               wr_elem_reg;
    logic [1:0]                  bank_full_reg, bank_full_next;
    logic                        done_reg, done_next;
    logic                        wr_ready;
    logic                        wr_fire;
    logic                        wr_wrap;
    logic                        stream_end;
    logic [LANES-1:0]            valid_vec;
    logic [LANES-1:0]            last_vec;
    logic [LANES*DATA_WIDTH-1:0] data_flat;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign wr_ready = !bank_full_reg[wb_reg] && !flush_i;
    assign wr_fire  = bus.wr_valid_i && wr_ready;
    assign wr_wrap  = wr_fire
                   && (wr_lane_reg == LW'(LANES - 1))
                   && (wr_elem_reg == EW'(DEPTH - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_lane_reg <= '0;
            wr_elem_reg <= '0;
            wb_reg      <= 1'b0;
        end else if (flush_i) begin
            wr_lane_reg <= '0;
            wr_elem_reg <= '0;
            wb_reg      <= 1'b0;
        end else if (wr_fire) begin
            if (wr_elem_reg == EW'(DEPTH - 1)) begin
                wr_elem_reg <= '0;
                if (wr_lane_reg == LW'(LANES - 1)) begin
                    wr_lane_reg <= '0;
                    wb_reg      <= !wb_reg;
                end else begin
                    wr_lane_reg <= wr_lane_reg + LW'(1);
                end
            end else begin
                wr_elem_reg <= wr_elem_reg + EW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        rb_next    = rb_reg;
        stream_end = 1'b0;
        case (state_reg)
            IDLE: begin
                if (((AUTO_START != 0) || bus.start_i) && bank_full_reg[rb_reg]) begin
                    state_next = STREAM;
                    step_next  = '0;
                end
            end
            STREAM: begin
                if (bus.advance_i) begin
                    if (step_reg == TW'(STEPS - 1)) begin
                        stream_end = 1'b1;
                        rb_next    = !rb_reg;
                        step_next  = '0;
                        // Auto mode chains straight into the other bank when it is already loaded.
                        state_next = ((AUTO_START != 0) && bank_full_reg[!rb_reg]) ? STREAM : IDLE;
                    end else begin
                        step_next = step_reg + TW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                step_next  = '0;
            end
        endcase
    end

    // The two flag updates always target different banks, so both may apply in one cycle.
    always_comb begin
        bank_full_next = bank_full_reg;
        if (wr_wrap) begin
            bank_full_next[wb_reg] = 1'b1;
        end
        if (stream_end) begin
            bank_full_next[rb_reg] = 1'b0;
        end
        done_next = stream_end;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg     <= IDLE;
            step_reg      <= '0;
            rb_reg        <= 1'b0;
            bank_full_reg <= 2'b00;
            done_reg      <= 1'b0;
        end else if (flush_i) begin
            state_reg     <= IDLE;
            step_reg      <= '0;
            rb_reg        <= 1'b0;
            bank_full_reg <= 2'b00;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            step_reg      <= step_next;
            rb_reg        <= rb_next;
            bank_full_reg <= bank_full_next;
            done_reg      <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane storage (both banks) and skewed output registers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [TW:0] LANE_IDX = (TW + 1)'(gi);

            logic [DATA_WIDTH-1:0] lane_mem [2*DEPTH];
            logic [TW:0]           elem_off;
            logic                  elem_hit;
            logic [AW-1:0]         rd_addr;
            logic [AW-1:0]         wr_addr;
            logic [DATA_WIDTH-1:0] data_reg;
            logic                  valid_reg;
            logic                  last_reg;

            // Element index k = t - lane, one bit wider than t so the range test cannot wrap.
            assign elem_off = {1'b0, step_reg} - LANE_IDX;
            assign elem_hit = ({1'b0, step_reg} >= LANE_IDX) && (elem_off < (TW + 1)'(DEPTH));
            assign rd_addr  = rb_reg ? (AW'(DEPTH) + AW'(elem_off)) : AW'(elem_off);
            assign wr_addr  = wb_reg ? (AW'(DEPTH) + AW'(wr_elem_reg)) : AW'(wr_elem_reg);

            always_ff @(posedge clk_i) begin
                if (wr_fire && (wr_lane_reg == LW'(gi))) begin
                    lane_mem[wr_addr] <= bus.wr_data_i;
                end
            end

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                end else if (flush_i) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                end else if (bus.advance_i) begin
                    if ((state_reg == STREAM) && elem_hit) begin
                        data_reg  <= lane_mem[rd_addr];
                        valid_reg <= 1'b1;
                        last_reg  <= (elem_off == (TW + 1)'(DEPTH - 1));
                    end else begin
                        data_reg  <= '0;
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                    end
                end
            end

            assign data_flat[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
            assign valid_vec[gi] = valid_reg;
            assign last_vec[gi]  = last_reg;
        end
    endgenerate

    assign bus.wr_ready_o  = wr_ready;
    assign bus.data_o      = data_flat;
    assign bus.valid_o     = valid_vec;
    assign bus.last_o      = last_vec;
    assign bus.bank_full_o = bank_full_reg;
    assign bus.busy_o      = (state_reg == STREAM);
    assign bus.done_o      = done_reg;
endmodule

// File: doc/pingpong_skew_feeder.md
Name: pingpong_skew_feeder

Overview:
- Parametrised, double-buffered successor to the row/column input queues that feed the mesh edges.
- Accepts one operand matrix (LANES lanes x DEPTH elements) over a streaming write port into one of two banks, while the other bank streams to the mesh.
- Streaming applies the diagonal skew: lane i lags lane 0 by i cycles.
- Adds per-lane valid/last tags, downstream stall, an optional auto-start mode and synchronous flush.

Parameters:
- LANES, 8: number of output lanes (mesh edge width); must be >= 1.
- DEPTH, 8: elements per lane per matrix (reduction length K); must be >= 1.
- DATA_WIDTH, 32: element width in bits.
- AUTO_START, 0: 1 = stream starts automatically when the read bank is full; 0 = stream waits for start_i.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous clear of banks, pointers and FSM.
- wr_valid_i  in  1  write beat valid.
- wr_data_i  in  DATA_WIDTH  write element.
- wr_ready_o  out  1  write beat accepted when wr_valid_i && wr_ready_o.
- start_i  in  1  begin streaming the read bank (ignored when AUTO_START=1).
- advance_i  in  1  downstream advance; 0 freezes the stream and all outputs.
- data_o  out  LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_o  out  LANES  per-lane element valid.
- last_o  out  LANES  per-lane final element (k = DEPTH-1).
- bank_full_o  out  2  full flag per bank.
- busy_o  out  1  FSM in STREAM.
- done_o  out  1  one-cycle pulse after the last step of a stream.

Behaviour:
- Reset (async) and flush_i (sync) produce the same state:
  - data_o=0, valid_o=0, last_o=0, bank_full_o=0, busy_o=0, done_o=0.
  - Write bank wb=0, read bank rb=0, write pointer=0, FSM=IDLE.
  - flush_i has priority over all other inputs in that cycle.
- Write side:
  - Load order is lane-major: beat n lands in lane n/DEPTH, element n%DEPTH.
  - wr_ready_o = !bank_full_o[wb] && !flush_i.
  - On the LANES*DEPTH-th accepted beat: set bank_full_o[wb], toggle wb, pointer returns to 0.
- Read FSM, IDLE -> STREAM:
  - Trigger: start_i (or AUTO_START) with bank_full_o[rb]=1.
  - start_i is ignored when bank_full_o[rb]=0 or the FSM is already in STREAM.
- STREAM step counter t runs 0..T-1, where T = DEPTH+LANES-1. t advances only on edges with advance_i=1.
- On each such edge, lane i registers element k = t-i:
  - If 0<=k<DEPTH: data = bank[rb][i][k], valid_o[i]=1, last_o[i] = (k==DEPTH-1).
  - Otherwise: data 0, valid 0, last 0.
- Latency: start_i sampled at edge E; t=0 outputs appear after the first edge > E with advance_i=1.
- When step T-1 loads:
  - Clear bank_full_o[rb], toggle rb, pulse done_o on the next cycle, FSM -> IDLE.
  - With AUTO_START=1 and the other bank full, go directly to STREAM. This gives back-to-back streams with no gap cycle.
- IDLE with advance_i=1: outputs register zeros. With advance_i=0, all outputs hold.
- Simultaneous write completion (bank wb) and stream completion (bank rb): both flag updates apply; they always target different banks.
- Stall mid-stream: the counter, outputs and skew relationship are all frozen. Writes continue independently.
- Reset or flush mid-stream: stream abandoned, no done_o pulse.
- Counters use $clog2-sized widths, minimum 1 bit. No arithmetic on data.

Test Plan:
- Reset values (LANES=4, DEPTH=3, DW=16): write 12 beats, value = lane*16+k; start_i.
  - Lane0 shows 0x00,0x01,0x02 on steps 0-2.
  - Lane3 shows 0x30,0x31,0x32 on steps 3-5.
  - last_o[3] is high on step 5; done_o pulses once; bank_full_o 01 -> 00.
- Ping-pong: write matrix A, start, and write matrix B during the stream.
  - wr_ready_o stays 1 throughout.
  - After done_o, bank_full_o=10 and a second start streams B intact.
- Back-pressure: fill both banks (24 beats).
  - wr_ready_o drops after beat 24; a 25th beat is not accepted.
  - It is accepted in the cycle after done_o frees bank 0.
- Stall: drop advance_i for 3 cycles during step 2.
  - Outputs hold the step-2 values; the sequence resumes at step 3; T stays 6 advancing steps.
- AUTO_START=1 with both banks full: two streams run back-to-back.
  - 12 consecutive advancing output cycles with no idle gap; two done_o pulses.
- Flush/reset mid-stream at step 3:
  - All outputs 0, bank_full_o=00, no done_o.
  - start_i is then ignored until a new 12-beat write completes.
